sqrt_csa_26bits_sub_seq: RTL and testbench

Multi-cycle inverse of the registered 26-bit square-root carry-select adder. Given a 27-bit adder result, the original `b` operand and the carry-in, it recovers `a = sum - b - c_in`. It processes one segment per cycle, using the adder's square-root partition of 2, 3, 4, 5, 6 and 6 bits, with a ripple borrow between segments. It sits on the check/readback path after the adder's 27-bit output register and confirms adder results without a second full-width subtractor.

---
 rtl/sqrt_csa_pkg.sv | 39 +++
 rtl/sqrt_csa_26bits_sub_seq_if.sv | 35 +++
 rtl/seg_sub_7bit.sv | 24 ++
 rtl/sqrt_csa_26bits_sub_seq.sv | 121 ++++++++++++
 tb/tb_sqrt_csa_26bits_sub_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sqrt_csa_pkg.sv
// Shared types and segment table for the sequential carry-select inverse.
// The partition mirrors the square-root carry-select adder it checks.
package sqrt_csa_pkg;

    localparam int SEG_CNT = 6;
    localparam int SEG_LSB [SEG_CNT] = '{0, 2, 5, 9, 14, 20};
    localparam int SEG_W   [SEG_CNT] = '{2, 3, 4, 5, 6, 6};

    typedef logic [2:0] seg_idx_t;

    localparam seg_idx_t SEG_LAST = seg_idx_t'(SEG_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int seg_clamp(input seg_idx_t s);
        return (s > SEG_LAST) ? SEG_CNT - 1 : int'(s);
    endfunction

    function automatic logic [4:0] seg_lsb(input seg_idx_t s);
        return 5'(SEG_LSB[seg_clamp(s)]);
    endfunction

    // The last segment also owns bit 26, so it spans all seven lanes.
    function automatic logic [6:0] seg_mask(input seg_idx_t s);
        logic [6:0] m;
        int         idx;
        idx = seg_clamp(s);
        m   = '0;
        for (int i = 0; i < 7; i++) begin
            m[i] = (i < SEG_W[idx]) || (idx == SEG_CNT - 1);
        end
        return m;
    endfunction

endpackage

// File: rtl/sqrt_csa_26bits_sub_seq_if.sv
// Request/result bundle between a requester and the sequential inverse.
interface sqrt_csa_26bits_sub_seq_if;

    logic        start;
    logic [26:0] sum_input;
    logic [25:0] b_input;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [25:0] a_output;
    logic        overflow;

    modport master (
        output start,
        output sum_input,
        output b_input,
        output c_in,
        input  busy,
        input  done,
        input  a_output,
        input  overflow
    );

    modport slave (
        input  start,
        input  sum_input,
        input  b_input,
        input  c_in,
        output busy,
        output done,
        output a_output,
        output overflow
    );

endinterface

// File: rtl/seg_sub_7bit.sv
// Combinational 7-bit ripple-borrow subtractor shared by all segments.
module seg_sub_7bit (
    input  logic [6:0] i_a,
    input  logic [6:0] i_b,
    input  logic       i_bin,
    output logic [6:0] o_diff,
    output logic       o_bout
);

    logic [7:0] w_br;

    always_comb begin
        w_br    = '0;
        o_diff  = '0;
        w_br[0] = i_bin;
        for (int i = 0; i < 7; i++) begin
            o_diff[i]  = i_a[i] ^ i_b[i] ^ w_br[i];
            w_br[i+1]  = (~i_a[i] & i_b[i])
                       | (~(i_a[i] ^ i_b[i]) & w_br[i]);
        end
        o_bout = w_br[7];
    end

endmodule

// File: rtl/sqrt_csa_26bits_sub_seq.sv
// Recovers a = sum - b - c_in one carry-select segment per falling edge.
module sqrt_csa_26bits_sub_seq
    import sqrt_csa_pkg::*;
#(
    parameter int W = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    sqrt_csa_26bits_sub_seq_if.slave   bus
);

    localparam int WX = W + 1;

    state_t      r_state;
    state_t      w_state_nx;
    logic [W:0]  r_sum;
    logic [W-1:0] r_b;
    logic [W:0]  r_work;
    logic        r_borrow;
    seg_idx_t    r_seg;
    logic [W-1:0] r_a;
    logic        r_ovf;

    logic [4:0]  w_lsb;
    logic [6:0]  w_mask;
    logic [6:0]  w_a_seg;
    logic [6:0]  w_b_seg;
    logic [6:0]  w_diff;
    logic        w_bout;
    logic        w_last;
    logic [W:0]  w_work_nx;

    assign w_lsb   = seg_lsb(r_seg);
    assign w_mask  = seg_mask(r_seg);
    assign w_last  = (r_seg == SEG_LAST);
    assign w_a_seg = 7'(r_sum >> w_lsb) & w_mask;
    // b has no bit 26; the zero pad lets seg5 subtract it as 0.
    assign w_b_seg = 7'({1'b0, r_b} >> w_lsb) & w_mask;

    seg_sub_7bit u_sub (
        .i_a    (w_a_seg),
        .i_b    (w_b_seg),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    assign w_work_nx = r_work | (WX'(w_diff & w_mask) << w_lsb);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_sum    <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_seg    <= '0;
            r_a      <= '0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sum    <= bus.sum_input;
                        r_b      <= bus.b_input;
                        r_borrow <= bus.c_in;
                        r_seg    <= '0;
                        r_work   <= '0;
                    end
                end
                RUN: begin
                    r_work   <= w_work_nx;
                    r_borrow <= w_bout;
                    r_seg    <= r_seg + 1'b1;
                    if (w_last) begin
                        r_a   <= w_work_nx[W-1:0];
                        r_ovf <= w_bout | w_work_nx[W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a_output = r_a;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_sqrt_csa_26bits_sub_seq.sv
// Scoreboard bench: drivers queue expected results, a monitor checks on done.
module tb_sqrt_csa_26bits_sub_seq;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sqrt_csa_26bits_sub_seq_if bus ();

    sqrt_csa_26bits_sub_seq #(.W(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [25:0] a;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want 0 (cyc %0d)",
                         cyc);
            end else begin
                m_e = q.pop_front();
                check("a_output", 32'(bus.a_output), 32'(m_e.a));
                check("overflow", 32'(bus.overflow), 32'(m_e.ov));
                check("done_cycle", 32'(cyc), 32'(m_e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [26:0] s, input logic [25:0] b,
                         input logic c);
        bus.start     = 1'b1;
        bus.sum_input = s;
        bus.b_input   = b;
        bus.c_in      = c;
    endtask

    task automatic issue(input logic [26:0] s, input logic [25:0] b,
                         input logic c, input logic push,
                         input logic [25:0] ea, input logic eov);
        tick();
        drive(s, b, c);
        if (push) q.push_back('{ea, eov, cyc + 7});
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b0) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: got busy=%0b want 0", bus.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.sum_input = '0;
        bus.b_input   = '0;
        bus.c_in      = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'h0);
        check("rst_a", 32'(bus.a_output), 32'h0);
        reset = 1'b0;
        tick();

        // round trip with busy window checks
        tick();
        n = cyc;
        drive(27'h1CF1357, 26'h1234567, 1'b1);
        q.push_back('{26'h0ABCDEF, 1'b0, n + 7});
        tick();
        bus.start = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'h1);
        repeat (6) tick();
        check("busy_in_done", 32'(bus.busy), 32'h1);
        tick();
        check("busy_fall", 32'(bus.busy), 32'h0);

        issue(27'h7FFFFFF, 26'h3FFFFFF, 1'b1, 1'b1, 26'h3FFFFFF, 1'b0);
        wait_idle();
        issue(27'h4000000, 26'h0000000, 1'b1, 1'b1, 26'h3FFFFFF, 1'b0);
        wait_idle();
        issue(27'h7FFFFFF, 26'h0000000, 1'b0, 1'b1, 26'h3FFFFFF, 1'b1);
        wait_idle();
        issue(27'h0000000, 26'h0000001, 1'b0, 1'b1, 26'h3FFFFFF, 1'b1);
        wait_idle();

        // start while busy, with operand changes after the latch edge
        issue(27'h1CF1357, 26'h1234567, 1'b1, 1'b1, 26'h0ABCDEF, 1'b0);
        tick();
        tick();
        drive(27'h5555555, 26'h0AAAAAA, 1'b0);
        tick();
        bus.start = 1'b0;
        wait_idle();

        // held start: one result every 8 cycles
        tick();
        n = cyc;
        drive(27'h0000010, 26'h0000003, 1'b0);
        q.push_back('{26'h000000D, 1'b0, n + 7});
        q.push_back('{26'h000000D, 1'b0, n + 15});
        q.push_back('{26'h000000D, 1'b0, n + 23});
        repeat (17) tick();
        bus.start = 1'b0;
        wait_idle();

        // reset mid-RUN after a nonzero result with overflow
        issue(27'h0000000, 26'h0000001, 1'b0, 1'b1, 26'h3FFFFFF, 1'b1);
        wait_idle();
        issue(27'h1CF1357, 26'h1234567, 1'b1, 1'b0, 26'h0, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_done", 32'(bus.done), 32'h0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'h0);
        check("mid_rst_a", 32'(bus.a_output), 32'h0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        issue(27'h2000000, 26'h1000000, 1'b1, 1'b1, 26'h0FFFFFF, 1'b0);
        wait_idle();

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
